// File: rtl/mem_pkg.sv
// Shared types for the memory port arbiter: FSM states, owner tag, request bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, REQ, RESP} arb_state_e;

  typedef enum logic {OWNER_IF, OWNER_D} owner_e;

  // Attributes registered at capture and replayed on the memory port.
  typedef struct packed {
    logic                  we;
    logic [BE_WIDTH-1:0]   be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory handshakes around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: request/grant on each side; slave = arbiter, master = environment.
interface mem_port_arbiter_if;
  import mem_pkg::*;

  // fetch side
  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  if_gnt_o;
  logic                  if_rvalid_o;
  logic [DATA_WIDTH-1:0] if_rdata_o;
  // data side
  logic                  d_req_i;
  logic                  d_we_i;
  logic [BE_WIDTH-1:0]   d_be_i;
  logic [ADDR_WIDTH-1:0] d_addr_i;
  logic [DATA_WIDTH-1:0] d_wdata_i;
  logic                  d_gnt_o;
  logic                  d_rvalid_o;
  logic [DATA_WIDTH-1:0] d_rdata_o;
  // memory side
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [BE_WIDTH-1:0]   mem_be_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  proto_err_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output proto_err_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  proto_err_o
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data paths; data-first with fetch anti-starvation.
// Latency: requester gnt in cycle 0 (comb), mem_req_o from cycle 1, response passed through same cycle.
// Backpressure: one transaction outstanding; requests wait ungranted outside IDLE, mem_gnt_i stalls REQ.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk_i,
  input logic              rst_ni,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);

  arb_state_e           state_q, state_d;
  owner_e               owner_q;
  mem_req_t             req_q, req_win;
  logic [CNT_WIDTH-1:0] starve_cnt;
  logic                 any_req, win_if, capture, starved;

  assign starved = (starve_cnt == CNT_WIDTH'(STARVE_LIMIT));
  assign any_req = bus.if_req_i | bus.d_req_i;
  // Fetch only wins when data is absent or fetch has been passed over too often.
  assign win_if  = bus.if_req_i & (~bus.d_req_i | starved);
  assign capture = (state_q == IDLE) & any_req;

  // Fetch carries full byte enables and no write data.
  assign req_win = win_if ? '{we: 1'b0, be: '1, addr: bus.if_addr_i, wdata: '0}
                          : '{we: bus.d_we_i, be: bus.d_be_i, addr: bus.d_addr_i, wdata: bus.d_wdata_i};

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: IDLE -> REQ on capture, REQ -> RESP on mem grant, RESP -> IDLE on response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req)          state_d = REQ;
      REQ:     if (bus.mem_gnt_i)    state_d = RESP;
      RESP:    if (bus.mem_rvalid_i) state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Output logic: grants at capture, memory request in REQ, response routing in RESP.
  always_comb begin
    bus.if_gnt_o    = 1'b0;
    bus.d_gnt_o     = 1'b0;
    bus.mem_req_o   = 1'b0;
    bus.if_rvalid_o = 1'b0;
    bus.d_rvalid_o  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.if_gnt_o = capture & win_if;
        bus.d_gnt_o  = capture & ~win_if;
      end
      REQ:  bus.mem_req_o = 1'b1;
      RESP: begin
        bus.if_rvalid_o = bus.mem_rvalid_i & (owner_q == OWNER_IF);
        bus.d_rvalid_o  = bus.mem_rvalid_i & (owner_q == OWNER_D);
      end
      default: ;
    endcase
  end

  assign bus.mem_we_o    = req_q.we;
  assign bus.mem_be_o    = req_q.be;
  assign bus.mem_addr_o  = req_q.addr;
  assign bus.mem_wdata_o = req_q.wdata;
  assign bus.if_rdata_o  = bus.mem_rdata_i;
  assign bus.d_rdata_o   = bus.mem_rdata_i;

  // Capture the winner's attributes and ownership; held untouched until the next capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q   <= '0;
      owner_q <= OWNER_D;
    end else if (capture) begin
      req_q   <= req_win;
      owner_q <= win_if ? OWNER_IF : OWNER_D;
    end
  end

  // Count consecutive data wins over a waiting fetch, saturating at the limit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt <= '0;
    end else if (capture) begin
      if (!win_if && bus.if_req_i) begin
        if (!starved) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  // Sticky flag for a memory response with nothing outstanding; such responses are dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                    bus.proto_err_o <= 1'b0;
    else if (bus.mem_rvalid_i && state_q != RESP)   bus.proto_err_o <= 1'b1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 1ns later.
// Backpressure: the bench plays the memory, choosing grant and response delays per vector.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req_i     = 1'b0;
    bus.if_addr_i    = '0;
    bus.d_req_i      = 1'b0;
    bus.d_we_i       = 1'b0;
    bus.d_be_i       = '0;
    bus.d_addr_i     = '0;
    bus.d_wdata_i    = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
  endtask

  // All outputs quiet, as after reset.
  task automatic chk_quiet(input string tag);
    chk({tag, "_mreq"},  bus.mem_req_o,   0);
    chk({tag, "_mwe"},   bus.mem_we_o,    0);
    chk({tag, "_mbe"},   bus.mem_be_o,    0);
    chk({tag, "_maddr"}, bus.mem_addr_o,  0);
    chk({tag, "_mwd"},   bus.mem_wdata_o, 0);
    chk({tag, "_gnt"},   {bus.if_gnt_o, bus.d_gnt_o}, 0);
    chk({tag, "_rv"},    {bus.if_rvalid_o, bus.d_rvalid_o}, 0);
    chk({tag, "_perr"},  bus.proto_err_o, 0);
  endtask

  // IDLE cycle with requests already driven: check which side is granted, advance to REQ.
  task automatic grant(input string tag, input bit exp_if);
    #1;
    chk({tag, "_ifgnt"}, bus.if_gnt_o, exp_if);
    chk({tag, "_dgnt"},  bus.d_gnt_o,  !exp_if);
    tick();
  endtask

  // Play memory from the first REQ cycle: grant after gdly stall cycles, respond rdly cycles after grant.
  task automatic serve(input string tag, input bit own_if, input int gdly, input int rdly,
                       input logic [31:0] a, input logic w, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] rd);
    for (int i = 0; i <= gdly; i++) begin
      bus.mem_gnt_i = (i == gdly);
      #1;
      chk({tag, "_req"},   bus.mem_req_o,   1);
      chk({tag, "_addr"},  bus.mem_addr_o,  a);
      chk({tag, "_we"},    bus.mem_we_o,    w);
      chk({tag, "_be"},    bus.mem_be_o,    be);
      chk({tag, "_wdata"}, bus.mem_wdata_o, wd);
      chk({tag, "_nogntq"}, {bus.if_gnt_o, bus.d_gnt_o}, 0);
      tick();
    end
    bus.mem_gnt_i = 1'b0;
    for (int i = 1; i < rdly; i++) begin
      #1;
      chk({tag, "_reqoff"}, bus.mem_req_o, 0);
      chk({tag, "_norv"},   {bus.if_rvalid_o, bus.d_rvalid_o}, 0);
      chk({tag, "_nogntr"}, {bus.if_gnt_o, bus.d_gnt_o}, 0);
      tick();
    end
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = rd;
    #1;
    chk({tag, "_ifrv"}, bus.if_rvalid_o, own_if);
    chk({tag, "_drv"},  bus.d_rvalid_o,  !own_if);
    chk({tag, "_rdata"}, own_if ? bus.if_rdata_o : bus.d_rdata_o, rd);
    tick();
    bus.mem_rvalid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic exp_if;
    rst_n = 1'b0;
    idle_inputs();

    // Reset state
    tick();
    #1 chk_quiet("reset");
    rst_n = 1'b1;
    tick();

    // 1: lone fetch, mem gnt immediately, rvalid two cycles after gnt
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h8000_0000;
    grant("t1", 1'b1);
    bus.if_req_i  = 1'b0;
    serve("t1", 1'b1, 0, 2, 32'h8000_0000, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF);

    // 2: both request together; data first, fetch at the next IDLE
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0100;
    bus.d_req_i   = 1'b1;
    bus.d_addr_i  = 32'h0000_0200;
    bus.d_be_i    = 4'hF;
    grant("t2d", 1'b0);
    bus.d_req_i   = 1'b0;
    serve("t2d", 1'b0, 0, 1, 32'h0000_0200, 1'b0, 4'hF, 32'h0, 32'h1111_2222);
    grant("t2i", 1'b1);
    bus.if_req_i  = 1'b0;
    serve("t2i", 1'b1, 0, 1, 32'h0000_0100, 1'b0, 4'hF, 32'h0, 32'h3333_4444);

    // 3: both held high; expected order D,D,D,D,IF,D,D,D,D,IF
    bus.if_req_i = 1'b1;
    bus.d_req_i  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp_if = (k == 4 || k == 9);
      grant($sformatf("t3_%0d", k), exp_if);
      serve($sformatf("t3_%0d", k), exp_if, 0, 1,
            exp_if ? 32'h0000_0100 : 32'h0000_0200, 1'b0, 4'hF, 32'h0, 32'hA000_0000 + k);
    end
    bus.if_req_i = 1'b0;
    bus.d_req_i  = 1'b0;

    // 4: data write with memory grant stalled three cycles
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b1;
    bus.d_be_i    = 4'b0011;
    bus.d_addr_i  = 32'h0000_0300;
    bus.d_wdata_i = 32'h1234_5678;
    grant("t4", 1'b0);
    idle_inputs();
    serve("t4", 1'b0, 3, 1, 32'h0000_0300, 1'b1, 4'b0011, 32'h1234_5678, 32'h0);
    #1 chk("t4_once", bus.d_rvalid_o, 0);
    tick();

    // 5: stray response in IDLE: not routed, sticky error
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h5555_AAAA;
    #1 chk("t5_norv", {bus.if_rvalid_o, bus.d_rvalid_o}, 0);
    tick();
    bus.mem_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_perr", bus.proto_err_o, 1);
      tick();
    end

    // 6: reset during RESP, then a clean fetch
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0400;
    grant("t6", 1'b1);
    bus.if_req_i  = 1'b0;
    bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    rst_n            = 1'b0;
    #1 chk_quiet("t6_rst");
    tick();
    chk_quiet("t6_rst2");
    bus.mem_rvalid_i = 1'b0;
    rst_n = 1'b1;
    tick();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0500;
    grant("t6f", 1'b1);
    bus.if_req_i  = 1'b0;
    serve("t6f", 1'b1, 0, 1, 32'h0000_0500, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D);
    #1 chk("t6f_perr", bus.proto_err_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
